// File: rtl/led_pattern_driver_pkg.sv
// LedCfg: shared definitions for the LED pattern driver.
//   - bit positions of the fields inside the 32-bit LED config word
//   - mode_t: pattern mode carried in cfg[1:0]
//   - state_t: pattern FSM states
//   - entry_state(): FSM state entered when a config of a given mode is loaded
// GPIO bus address constants live in IOAddress, not here.
package LedCfg;

    localparam int unsigned CFG_W      = 32;
    localparam int unsigned FIELD_W    = 8;
    localparam int unsigned MODE_W     = 2;
    localparam int unsigned MASK_LSB   = 24;
    localparam int unsigned DUTY_LSB   = 16;
    localparam int unsigned PERIOD_LSB = 8;
    localparam int unsigned MODE_LSB   = 0;

    typedef enum logic [1:0] {
        M_OFF     = 2'd0,
        M_STATIC  = 2'd1,
        M_BLINK   = 2'd2,
        M_BREATHE = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        S_OFF,
        S_STATIC,
        S_BLINK_ON,
        S_BLINK_OFF,
        S_BRTH_UP,
        S_BRTH_DN
    } state_t;

    function automatic state_t entry_state(input mode_t m);
        case (m)
            M_OFF:    return S_OFF;
            M_STATIC: return S_STATIC;
            M_BLINK:  return S_BLINK_ON;
            default:  return S_BRTH_UP;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_driver_tick_gen.sv
// tick_gen: pattern-tick prescaler.
// Counts 0..DIV-1 and raises tick for the single cycle in which the count
// sits at DIV-1 (the wrap cycle). clr restarts the count at 0 on the next edge.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous, active-low reset
//   clr   in  synchronous restart of the prescaler
//   tick  out 1-cycle pulse every DIV cycles
module tick_gen #(
    parameter int unsigned DIV = 125000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/led_pattern_driver.sv
// led_pattern_driver: drives board LEDs from the word assembled by the LED
// config register. Intermediate values seen while bytes are shifted in are
// filtered by a settle counter; a settled word is applied at the next PWM
// frame boundary so the change is glitch-free.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-low reset
//   cfg_in       in   [31:0] live config word
//                     [31:24] led_mask [23:16] duty [15:8] period [1:0] mode
//   led          out  [NUM_LEDS-1:0] registered LED drive, 1 = on
//   cfg_active   out  [31:0] config word currently applied
//   cfg_pending  out  settled word waiting for the frame boundary
module led_pattern_driver
    import LedCfg::*;
#(
    parameter int unsigned NUM_LEDS      = 8,
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned TICK_DIV      = 125000,
    parameter int unsigned SETTLE_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CFG_W-1:0]    cfg_in,
    output logic [NUM_LEDS-1:0] led,
    output logic [CFG_W-1:0]    cfg_active,
    output logic                cfg_pending
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    logic [CFG_W-1:0]    cfg_prev_q,    cfg_prev_d;
    logic [SW-1:0]       settle_cnt_q,  settle_cnt_d;
    logic [CFG_W-1:0]    cfg_active_q,  cfg_active_d;
    logic                cfg_pending_q, cfg_pending_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,     pwm_cnt_d;
    logic [8:0]          step_cnt_q,    step_cnt_d;
    logic [PWM_BITS-1:0] env_q,         env_d;
    state_t              state_q,       state_d;
    logic [NUM_LEDS-1:0] led_q,         led_d;

    logic                stable;
    logic                load;
    logic                tick;
    logic                step_done;
    logic [FIELD_W-1:0]  act_duty;
    logic [FIELD_W-1:0]  act_period;
    logic [NUM_LEDS-1:0] act_mask;
    logic [PWM_BITS-1:0] duty_al;
    logic [PWM_BITS-1:0] duty_eff;
    logic                pwm_on;

    assign act_duty   = cfg_active_q[DUTY_LSB +: FIELD_W];
    assign act_period = cfg_active_q[PERIOD_LSB +: FIELD_W];
    assign act_mask   = cfg_active_q[MASK_LSB +: NUM_LEDS];

    // duty is 8 bits; align its MSB with the PWM counter MSB.
    generate
        if (PWM_BITS > FIELD_W) begin : g_duty_pad
            assign duty_al = {act_duty, {(PWM_BITS - FIELD_W){1'b0}}};
        end else if (PWM_BITS == FIELD_W) begin : g_duty_eq
            assign duty_al = act_duty;
        end else begin : g_duty_trunc
            assign duty_al = act_duty[FIELD_W-1 -: PWM_BITS];
        end
    endgenerate

    // ---------------------------------------------------------------
    // Settle filter, shadow register, PWM counter
    // ---------------------------------------------------------------
    assign stable = (cfg_in == cfg_prev_q);
    // Load only at the last count of a frame and only with the very word
    // that settled; a change on that same edge cancels the load.
    assign load   = cfg_pending_q && stable && (pwm_cnt_q == '1);

    always_comb begin
        cfg_prev_d    = cfg_in;
        settle_cnt_d  = settle_cnt_q;
        cfg_pending_d = cfg_pending_q;
        cfg_active_d  = cfg_active_q;
        pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);

        if (!stable) begin
            settle_cnt_d = '0;
        end else if (settle_cnt_q != SETTLE_LAST) begin
            settle_cnt_d = settle_cnt_q + SW'(1);
        end

        // A word equal to the one already applied never becomes pending,
        // so re-writing the same config leaves the pattern phase alone.
        if (!stable || (cfg_in == cfg_active_q)) begin
            cfg_pending_d = 1'b0;
        end else if (settle_cnt_q == SETTLE_LAST) begin
            cfg_pending_d = 1'b1;
        end

        if (load) begin
            cfg_active_d  = cfg_in;
            cfg_pending_d = 1'b0;
        end
    end

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .tick(tick)
    );

    // ---------------------------------------------------------------
    // Pattern FSM: next state and effective duty
    // ---------------------------------------------------------------
    assign step_done = (step_cnt_q == {1'b0, act_period});

    always_comb begin
        state_d    = state_q;
        env_d      = env_q;
        step_cnt_d = step_cnt_q;
        duty_eff   = '0;

        case (state_q)
            S_OFF: begin
                duty_eff = '0;
            end
            S_STATIC: begin
                duty_eff = duty_al;
            end
            S_BLINK_ON, S_BLINK_OFF: begin
                duty_eff = (state_q == S_BLINK_ON) ? duty_al : '0;
                if (tick) begin
                    if (step_done) begin
                        step_cnt_d = '0;
                        state_d    = (state_q == S_BLINK_ON) ? S_BLINK_OFF : S_BLINK_ON;
                    end else begin
                        step_cnt_d = step_cnt_q + 9'd1;
                    end
                end
            end
            S_BRTH_UP: begin
                duty_eff = (env_q < duty_al) ? env_q : duty_al;
                if (tick) begin
                    if (env_q == '1) begin
                        state_d = S_BRTH_DN;
                        env_d   = env_q - PWM_BITS'(1);
                    end else begin
                        env_d   = env_q + PWM_BITS'(1);
                    end
                end
            end
            S_BRTH_DN: begin
                duty_eff = (env_q < duty_al) ? env_q : duty_al;
                if (tick) begin
                    if (env_q == '0) begin
                        state_d = S_BRTH_UP;
                        env_d   = env_q + PWM_BITS'(1);
                    end else begin
                        env_d   = env_q - PWM_BITS'(1);
                    end
                end
            end
            default: begin
                state_d = S_OFF;
            end
        endcase

        // Applied last so a tick coinciding with a load is discarded.
        if (load) begin
            state_d    = entry_state(mode_t'(cfg_in[MODE_LSB +: MODE_W]));
            env_d      = '0;
            step_cnt_d = '0;
        end
    end

    // ---------------------------------------------------------------
    // PWM compare and LED register
    // ---------------------------------------------------------------
    assign pwm_on = (duty_eff == '1) || (pwm_cnt_q < duty_eff);

    always_comb begin
        led_d = {NUM_LEDS{pwm_on}} & act_mask;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_prev_q    <= '0;
            settle_cnt_q  <= '0;
            cfg_active_q  <= '0;
            cfg_pending_q <= 1'b0;
            pwm_cnt_q     <= '0;
            step_cnt_q    <= '0;
            env_q         <= '0;
            state_q       <= S_OFF;
            led_q         <= '0;
        end else begin
            cfg_prev_q    <= cfg_prev_d;
            settle_cnt_q  <= settle_cnt_d;
            cfg_active_q  <= cfg_active_d;
            cfg_pending_q <= cfg_pending_d;
            pwm_cnt_q     <= pwm_cnt_d;
            step_cnt_q    <= step_cnt_d;
            env_q         <= env_d;
            state_q       <= state_d;
            led_q         <= led_d;
        end
    end

    assign led         = led_q;
    assign cfg_active  = cfg_active_q;
    assign cfg_pending = cfg_pending_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver with PWM_BITS=4, TICK_DIV=4, SETTLE_CYCLES=8,
// NUM_LEDS=4. cyc counts posedges since the last reset release, so the DUT
// PWM counter equals cyc % 16 after each edge and frame loads land on edges
// where cyc % 16 == 0.
module tb_led_pattern_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfg_in = '0;
    logic [3:0]  led;
    logic [31:0] cfg_active;
    logic        cfg_pending;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc;
    logic [3:0]  exp_q[$];

    led_pattern_driver #(
        .NUM_LEDS     (4),
        .PWM_BITS     (4),
        .TICK_DIV     (4),
        .SETTLE_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_in     (cfg_in),
        .led        (led),
        .cfg_active (cfg_active),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got cyc=%0d required finish", cyc);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic align(input int unsigned r);
        for (int i = 0; i < 16 && (cyc % 16) != r; i++) step();
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset();
        logic [3:0] e;
        #2 rst = 1'b0;
        #3;
        n_cmp++; if (led !== 4'h0) begin n_err++; $display("FAIL reset_led: got %h required 0", led); end
        n_cmp++; if (cfg_active !== 32'h0) begin n_err++; $display("FAIL reset_active: got %h required 0", cfg_active); end
        n_cmp++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending: got %b required 0", cfg_pending); end
        #17 rst = 1'b1;
        for (int i = 0; i < 100; i++) exp_q.push_back(4'h0);
        for (int i = 0; i < 100; i++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++; if (led !== e) begin n_err++; $display("FAIL idle_led cyc=%0d: got %h required %h", cyc, led, e); end
            n_cmp++; if (cfg_active !== 32'h0) begin n_err++; $display("FAIL idle_active cyc=%0d: got %h required 0", cyc, cfg_active); end
            n_cmp++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL idle_pending cyc=%0d: got %b required 0", cyc, cfg_pending); end
        end
    endtask

    // ---------------------------------------------------------------
    task automatic test_shift();
        logic [31:0] bytes_w [4];
        logic [3:0]  e;
        bytes_w[0] = 32'h0000000F;
        bytes_w[1] = 32'h00000FFF;
        bytes_w[2] = 32'h000FFF00;
        bytes_w[3] = 32'h0FFF0001;
        align(7);
        for (int b = 0; b < 3; b++) begin
            cfg_in = bytes_w[b];
            for (int i = 0; i < 3; i++) begin
                step();
                n_cmp++; if (cfg_active !== 32'h0) begin n_err++; $display("FAIL shift_no_load cyc=%0d: got %h required 0", cyc, cfg_active); end
                n_cmp++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL shift_no_pending cyc=%0d: got %b required 0", cyc, cfg_pending); end
            end
        end
        cfg_in = bytes_w[3];
        for (int k = 1; k <= 64; k++) exp_q.push_back((k <= 16) ? 4'h0 : 4'hF);
        for (int k = 1; k <= 64; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++; if (led !== e) begin n_err++; $display("FAIL shift_led k=%0d: got %h required %h", k, led, e); end
            if (k < 16) begin
                n_cmp++; if (cfg_active !== 32'h0) begin n_err++; $display("FAIL shift_early_load k=%0d: got %h required 0", k, cfg_active); end
            end
            if (k == 15) begin
                n_cmp++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL shift_pending: got %b required 1", cfg_pending); end
            end
            if (k == 16) begin
                n_cmp++; if (cfg_active !== 32'h0FFF0001) begin n_err++; $display("FAIL shift_load: got %h required 0fff0001", cfg_active); end
                n_cmp++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL shift_pending_clr: got %b required 0", cfg_pending); end
            end
        end
    endtask

    // ---------------------------------------------------------------
    task automatic test_static();
        logic [3:0] e;
        align(0);
        cfg_in = 32'h01800001;
        // previous config (all LEDs full on) holds until the frame load at k=16
        for (int k = 1; k <= 64; k++)
            exp_q.push_back((k <= 16) ? 4'hF : ((((k - 1) % 16) < 8) ? 4'h1 : 4'h0));
        for (int k = 1; k <= 64; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++; if (led !== e) begin n_err++; $display("FAIL static_led k=%0d: got %h required %h", k, led, e); end
            if (k == 16) begin
                n_cmp++; if (cfg_active !== 32'h01800001) begin n_err++; $display("FAIL static_load: got %h required 01800001", cfg_active); end
            end
        end
    endtask

    // ---------------------------------------------------------------
    task automatic test_blink();
        logic [3:0] e;
        align(0);
        cfg_in = 32'h03FF0202;
        for (int k = 1; k <= 88; k++) begin
            if (k <= 16) e = ((((k - 1) % 16) < 8) ? 4'h1 : 4'h0);
            else         e = ((((k - 17) % 24) < 12) ? 4'h3 : 4'h0);
            exp_q.push_back(e);
        end
        for (int k = 1; k <= 88; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++; if (led !== e) begin n_err++; $display("FAIL blink_led k=%0d: got %h required %h", k, led, e); end
            if (k == 16) begin
                n_cmp++; if (cfg_active !== 32'h03FF0202) begin n_err++; $display("FAIL blink_load: got %h required 03ff0202", cfg_active); end
            end
        end
    endtask

    // ---------------------------------------------------------------
    task automatic test_breathe();
        logic [3:0]  e;
        int unsigned t, env;
        align(0);
        cfg_in = 32'h01FF0003;
        for (int k = 0; k < 240; k++) begin
            t   = (k / 4) % 30;
            env = (t <= 15) ? t : 30 - t;
            e   = ((env == 15) || ((k % 16) < env)) ? 4'h1 : 4'h0;
            exp_q.push_back(e);
        end
        for (int k = 1; k <= 16; k++) step();
        n_cmp++; if (cfg_active !== 32'h01FF0003) begin n_err++; $display("FAIL breathe_load: got %h required 01ff0003", cfg_active); end
        for (int k = 0; k < 240; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++; if (led !== e) begin n_err++; $display("FAIL breathe_led k=%0d: got %h required %h", k, led, e); end
        end
    endtask

    // ---------------------------------------------------------------
    task automatic test_reset_mid_blink();
        logic [3:0]  e;
        logic [31:0] v;
        v = 32'h03FF0202;
        align(0);
        cfg_in = v;
        for (int k = 1; k <= 21; k++) step();
        n_cmp++; if (led !== 4'h3) begin n_err++; $display("FAIL rst_pre_led: got %h required 3", led); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (led !== 4'h0) begin n_err++; $display("FAIL rst_led_off: got %h required 0", led); end
        n_cmp++; if (cfg_active !== 32'h0) begin n_err++; $display("FAIL rst_active: got %h required 0", cfg_active); end
        n_cmp++; if (cfg_pending !== 1'b0) begin n_err++; $display("FAIL rst_pending: got %b required 0", cfg_pending); end
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b1;
        // settle restarts on the 7th cycle, so the frame at edge 16 is missed
        for (int k = 1; k <= 80; k++)
            exp_q.push_back((k <= 32) ? 4'h0 : ((((k - 33) % 24) < 12) ? 4'h3 : 4'h0));
        for (int k = 1; k <= 80; k++) begin
            step();
            e = exp_q.pop_front();
            n_cmp++; if (led !== e) begin n_err++; $display("FAIL rst_resume_led k=%0d: got %h required %h", k, led, e); end
            if (k < 32) begin
                n_cmp++; if (cfg_active !== 32'h0) begin n_err++; $display("FAIL rst_no_load k=%0d: got %h required 0", k, cfg_active); end
            end
            if (k == 31) begin
                n_cmp++; if (cfg_pending !== 1'b1) begin n_err++; $display("FAIL rst_pending_set: got %b required 1", cfg_pending); end
            end
            if (k == 32) begin
                n_cmp++; if (cfg_active !== v) begin n_err++; $display("FAIL rst_reload: got %h required %h", cfg_active, v); end
            end
            if (k == 6) cfg_in = v ^ 32'h1;
            if (k == 9) cfg_in = v;
        end
    endtask

    initial begin
        test_reset();
        test_shift();
        test_static();
        test_blink();
        test_breathe();
        test_reset_mid_blink();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
